// File: rtl/ber_pkg.sv
// ----------------------------------------------------------------------------
// ber_pkg
// Shared definitions for the PRBS BER measurement path (prbs_generate,
// prbs_checker, ber_accumulator).
//   - ber_state_t    : measurement FSM state encoding
//   - BER_* defaults : word width, window length, accumulator width, timeout
//   - word_cnt_width : width of a counter that must reach a given count
// ----------------------------------------------------------------------------
package ber_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOCK = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } ber_state_t;

    localparam int unsigned BER_WIDTH          = 32'd8;
    localparam int unsigned BER_WINDOW_WORDS   = 32'd1024;
    localparam int unsigned BER_CNT_W          = 32'd32;
    localparam int unsigned BER_TIMEOUT_CYCLES = 32'd4096;

    // Bits needed to hold the values 0..count inclusive.
    function automatic int unsigned word_cnt_width(input int unsigned count);
        return $clog2(count + 32'd1);
    endfunction

endpackage

// File: rtl/ber_accumulator_sat_accum.sv
// ----------------------------------------------------------------------------
// sat_accum
// Saturating accumulator: value clamps at all-ones instead of wrapping and the
// sticky sat flag records that a clamp happened.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero value and sat (wins over add_en)
//   add_en     : add addend this cycle
//   addend     : CNT_W-bit unsigned increment
//   value      : registered accumulated value
//   sat        : registered sticky saturation flag
// ----------------------------------------------------------------------------
module sat_accum
    import ber_pkg::*;
#(
    parameter int unsigned CNT_W = BER_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             add_en,
    input  logic [CNT_W-1:0] addend,
    output logic [CNT_W-1:0] value,
    output logic             sat
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             sat_q, sat_d;
    logic [CNT_W:0]   sum;

    // Next value: an extra carry bit on the sum detects overflow.
    always_comb begin
        value_d = value_q;
        sat_d   = sat_q;
        sum     = {1'b0, value_q} + {1'b0, addend};
        if (clr) begin
            value_d = {CNT_W{1'b0}};
            sat_d   = 1'b0;
        end else if (add_en) begin
            if (sum[CNT_W]) begin
                value_d = {CNT_W{1'b1}};
                sat_d   = 1'b1;
            end else begin
                value_d = sum[CNT_W-1:0];
            end
        end else begin
            value_d = value_q;
        end
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= {CNT_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_q;
    assign sat   = sat_q;

endmodule

// File: rtl/ber_accumulator.sv
// ----------------------------------------------------------------------------
// ber_accumulator
// Counts bits compared and bit errors over a window of WINDOW_WORDS locked,
// enabled words from prbs_checker; BER = err_cnt / bit_cnt.
//   clk, reset : clock, synchronous active-high reset
//   en, lock   : word-valid qualifier and checker lock status
//   err_num    : bit errors in the current word (0..WIDTH, not range-checked)
//   start      : single-cycle measurement request (ignored while busy)
//   busy       : high in WAIT_LOCK and MEASURE
//   done       : one-cycle pulse on entry to DONE, counts final that cycle
//   bit_cnt    : accumulated bits compared (saturating)
//   err_cnt    : accumulated bit errors (saturating)
//   lock_lost  : sticky, lock dropped on an enabled word during MEASURE
//   sat        : sticky, either accumulator saturated
//   timeout    : sticky, only with BER_TIMEOUT_EN; lock not seen within
//                TIMEOUT_CYCLES cycles of WAIT_LOCK
// Optional feature macro: BER_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module ber_accumulator
    import ber_pkg::*;
#(
    parameter int unsigned WIDTH          = BER_WIDTH,
    parameter int unsigned WINDOW_WORDS   = BER_WINDOW_WORDS,
    parameter int unsigned CNT_W          = BER_CNT_W
`ifdef BER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = BER_TIMEOUT_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             lock,
    input  logic [WIDTH:0]   err_num,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             lock_lost,
    output logic             sat
`ifdef BER_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int unsigned      WC_W      = word_cnt_width(WINDOW_WORDS);
    localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(WINDOW_WORDS - 32'd1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(WIDTH);

    ber_state_t       state_q, state_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lock_lost_q, lock_lost_d;
    logic             clr;
    logic             count_word;
    logic             bit_sat, err_sat;
    logic [CNT_W-1:0] err_addend;

`ifdef BER_TIMEOUT_EN
    localparam int unsigned     TC_W     = word_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TC_W-1:0] LAST_TMO = TC_W'(TIMEOUT_CYCLES - 32'd1);
    logic [TC_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // FSM next state, window counting and flag updates.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        lock_lost_d = lock_lost_q;
        clr         = 1'b0;
        count_word  = 1'b0;
`ifdef BER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // New measurement discards the previous result.
                    state_d     = WAIT_LOCK;
                    clr         = 1'b1;
                    word_cnt_d  = {WC_W{1'b0}};
                    lock_lost_d = 1'b0;
`ifdef BER_TIMEOUT_EN
                    tmo_cnt_d   = {TC_W{1'b0}};
                    timeout_d   = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            WAIT_LOCK: begin
                if (lock) begin
                    state_d = MEASURE;
                end
`ifdef BER_TIMEOUT_EN
                else if (tmo_cnt_q == LAST_TMO) begin
                    // Give up; accumulators are still zero from the clear.
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TC_W'(1);
                end
`else
                else begin
                    state_d = WAIT_LOCK;
                end
`endif
            end
            MEASURE: begin
                if (en && lock) begin
                    count_word = 1'b1;
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        state_d = MEASURE;
                    end
                end else if (en) begin
                    // Enabled word arrived without lock: skip it, remember it.
                    lock_lost_d = 1'b1;
                end else begin
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == WAIT_LOCK) || (state_d == MEASURE);
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= {WC_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            lock_lost_q <= 1'b0;
`ifdef BER_TIMEOUT_EN
            tmo_cnt_q   <= {TC_W{1'b0}};
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            lock_lost_q <= lock_lost_d;
`ifdef BER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign err_addend = CNT_W'(err_num);

    sat_accum #(.CNT_W(CNT_W)) u_bit_accum (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .add_en (count_word),
        .addend (WORD_BITS),
        .value  (bit_cnt),
        .sat    (bit_sat)
    );

    sat_accum #(.CNT_W(CNT_W)) u_err_accum (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .add_en (count_word),
        .addend (err_addend),
        .value  (err_cnt),
        .sat    (err_sat)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign lock_lost = lock_lost_q;
    assign sat       = bit_sat | err_sat;
`ifdef BER_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule
